// File: rtl/a2_bridge_target.sv
// a2_bridge_target: target end of the A2Bridge bus; generates Apple clocks/reset,
// replays queued bus cycles and captures bytes written by the initiator.
module a2_bridge_target #(
    parameter int H7_CLKS          = 4,
    parameter int RESET_PHI_CYCLES = 4,
    parameter int DEPTH            = 4
) (
    input  logic        clk_logic,
    input  logic        reset,
    input  logic        cyc_valid_i,
    output logic        cyc_ready_o,
    input  logic [15:0] cyc_addr_i,
    input  logic [7:0]  cyc_data_i,
    input  logic [7:0]  cyc_ctrl_i,
    output logic        a2_phi1,
    output logic        a2_7M,
    output logic        a2_reset_n,
    input  logic [2:0]  a2_bridge_sel_i,
    input  logic        a2_bridge_bus_a_oe_n_i,
    input  logic        a2_bridge_bus_d_oe_n_i,
    input  logic        a2_bridge_rd_n_i,
    input  logic        a2_bridge_wr_n_i,
    input  logic [7:0]  a2_bridge_d_i,
    output logic [7:0]  a2_bridge_d_o,
    output logic        a2_bridge_d_oe_o,
    output logic        wr_valid_o,
    output logic [7:0]  wr_data_o,
    output logic [15:0] wr_addr_o,
    output logic [15:0] underrun_o
);
    localparam int DW = $clog2(H7_CLKS);
    localparam int RW = $clog2(RESET_PHI_CYCLES + 1);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    ph_q, ph_d;
    logic [RW-1:0] rise_q, rise_d;
    logic          m7_q, phi_q, rstn_q, rstn_d;
    logic          tog, rise, adv;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic          ready_q, push, pop;

    logic [15:0]   addr_q, und_q;
    logic [7:0]    data_q, ctrl_q;

    logic          oe_d, oe_q;
    logic [7:0]    byte_d, d_d, d_q;
    logic          hit, pend_q, wv_q;
    logic [7:0]    latch_q, wd_q;
    logic [15:0]   wa_q;

    assign tog    = div_q == DW'(H7_CLKS - 1);
    assign rise   = tog && ph_q == 3'd6 && !phi_q;
    assign adv    = rise && rstn_q;
    assign div_d  = tog ? '0 : div_q + 1'b1;
    assign ph_d   = !tog ? ph_q : (ph_q == 3'd6 ? 3'd0 : ph_q + 3'd1);
    assign rise_d = (rise && rise_q != RW'(RESET_PHI_CYCLES)) ? rise_q + 1'b1 : rise_q;
    // reset_n follows one clock after the counter reaches its target
    assign rstn_d = rstn_q || rise_q == RW'(RESET_PHI_CYCLES);

    assign push  = cyc_valid_i && ready_q;
    assign pop   = adv && cnt_q != '0;
    assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

    always_ff @(posedge clk_logic) begin
        if (reset) begin
            div_q   <= '0;
            ph_q    <= '0;
            rise_q  <= '0;
            m7_q    <= 1'b0;
            phi_q   <= 1'b0;
            rstn_q  <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= 8'hFF;
            ctrl_q  <= 8'hFF;
            und_q   <= '0;
        end else begin
            div_q   <= div_d;
            ph_q    <= ph_d;
            rise_q  <= rise_d;
            m7_q    <= m7_q ^ tog;
            phi_q   <= phi_q ^ (tog && ph_q == 3'd6);
            rstn_q  <= rstn_d;
            wp_q    <= wp_q + PW'(push);
            rp_q    <= rp_q + PW'(pop);
            cnt_q   <= cnt_d;
            ready_q <= cnt_d != (PW+1)'(DEPTH);
            if (pop) begin
                {addr_q, data_q, ctrl_q} <= mem_q[rp_q];
            end else if (adv) begin
                data_q <= 8'hFF;
                ctrl_q <= 8'hFF;
                und_q  <= (und_q == 16'hFFFF) ? und_q : und_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_logic) begin
        if (push) mem_q[wp_q] <= {cyc_addr_i, cyc_data_i, cyc_ctrl_i};
    end

    // a simultaneous write strobe suppresses the read response
    always_comb begin
        oe_d   = !a2_bridge_rd_n_i && a2_bridge_wr_n_i &&
                 (a2_bridge_sel_i[2] || (a2_bridge_sel_i[1] ? !a2_bridge_bus_d_oe_n_i : !a2_bridge_bus_a_oe_n_i));
        byte_d = a2_bridge_sel_i[2] ? 8'hFF :
                 a2_bridge_sel_i[1] ? (a2_bridge_sel_i[0] ? ctrl_q : data_q) :
                                      (a2_bridge_sel_i[0] ? addr_q[15:8] : addr_q[7:0]);
        d_d    = oe_d ? byte_d : 8'hFF;
    end

    assign hit = !a2_bridge_wr_n_i && a2_bridge_sel_i == 3'd2 && !a2_bridge_bus_d_oe_n_i;

    always_ff @(posedge clk_logic) begin
        if (reset) begin
            oe_q    <= 1'b0;
            d_q     <= 8'hFF;
            pend_q  <= 1'b0;
            wv_q    <= 1'b0;
            latch_q <= '0;
            wd_q    <= '0;
            wa_q    <= '0;
        end else begin
            oe_q   <= oe_d;
            d_q    <= d_d;
            wv_q   <= a2_bridge_wr_n_i && pend_q;
            pend_q <= hit || (pend_q && !a2_bridge_wr_n_i);
            if (a2_bridge_wr_n_i && pend_q) begin
                wd_q <= latch_q;
                wa_q <= addr_q;
            end
            if (hit) latch_q <= a2_bridge_d_i;
        end
    end

    assign cyc_ready_o      = ready_q;
    assign a2_phi1          = phi_q;
    assign a2_7M            = m7_q;
    assign a2_reset_n       = rstn_q;
    assign a2_bridge_d_o    = d_q;
    assign a2_bridge_d_oe_o = oe_q;
    assign wr_valid_o       = wv_q;
    assign wr_data_o        = wd_q;
    assign wr_addr_o        = wa_q;
    assign underrun_o       = und_q;
endmodule

// File: tb/tb_a2_bridge_target.sv
// tb_a2_bridge_target: random and directed stimulus checked against a time-based reference model.
module tb_a2_bridge_target;
    logic        clk_logic = 1'b0;
    logic        reset = 1'b1;
    logic        cyc_valid = 1'b0;
    logic        cyc_ready;
    logic [15:0] cyc_addr = '0;
    logic [7:0]  cyc_data = '0;
    logic [7:0]  cyc_ctrl = '0;
    logic        a2_phi1, a2_7M, a2_reset_n;
    logic [2:0]  sel = '0;
    logic        a_oe_n = 1'b1, d_oe_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0]  d_in = '0;
    logic [7:0]  d_out;
    logic        d_oe, wr_valid;
    logic [7:0]  wr_data;
    logic [15:0] wr_addr, underrun;

    int checks = 0;
    int errors = 0;

    int          t = 0;
    logic [31:0] q[$];
    logic        m_ready = 1'b0;
    logic [15:0] m_addr = '0, m_und = '0, m_wa = '0;
    logic [7:0]  m_data = 8'hFF, m_ctrl = 8'hFF, m_d = 8'hFF, m_wd = '0, lat = '0;
    logic        m_oe = 1'b0, m_wv = 1'b0, pend = 1'b0;

    a2_bridge_target #(.H7_CLKS(4), .RESET_PHI_CYCLES(4), .DEPTH(4)) dut (
        .clk_logic(clk_logic), .reset(reset),
        .cyc_valid_i(cyc_valid), .cyc_ready_o(cyc_ready),
        .cyc_addr_i(cyc_addr), .cyc_data_i(cyc_data), .cyc_ctrl_i(cyc_ctrl),
        .a2_phi1(a2_phi1), .a2_7M(a2_7M), .a2_reset_n(a2_reset_n),
        .a2_bridge_sel_i(sel), .a2_bridge_bus_a_oe_n_i(a_oe_n), .a2_bridge_bus_d_oe_n_i(d_oe_n),
        .a2_bridge_rd_n_i(rd_n), .a2_bridge_wr_n_i(wr_n), .a2_bridge_d_i(d_in),
        .a2_bridge_d_o(d_out), .a2_bridge_d_oe_o(d_oe),
        .wr_valid_o(wr_valid), .wr_data_o(wr_data), .wr_addr_o(wr_addr), .underrun_o(underrun)
    );

    always #5 clk_logic = ~clk_logic;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Model advances on each edge from the inputs held before it; outputs compared 1ns later.
    task automatic tick();
        logic r, v, rn, wn, aoe, doe;
        logic [2:0]  s;
        logic [7:0]  din, od, oc;
        logic [15:0] oa;
        logic [31:0] ent;
        r = reset; v = cyc_valid; rn = rd_n; wn = wr_n; aoe = a_oe_n; doe = d_oe_n;
        s = sel; din = d_in; ent = {cyc_addr, cyc_data, cyc_ctrl};
        @(posedge clk_logic);
        if (r) begin
            t = 0; q.delete(); m_ready = 1'b0;
            m_addr = '0; m_data = 8'hFF; m_ctrl = 8'hFF; m_und = '0;
            m_d = 8'hFF; m_oe = 1'b0; m_wv = 1'b0; m_wd = '0; m_wa = '0; pend = 1'b0;
        end else begin
            oa = m_addr; od = m_data; oc = m_ctrl;
            t++;
            m_oe = 1'b0; m_d = 8'hFF;
            if (!rn && wn) begin
                case (s)
                    3'd0: if (!aoe) begin m_oe = 1'b1; m_d = oa[7:0]; end
                    3'd1: if (!aoe) begin m_oe = 1'b1; m_d = oa[15:8]; end
                    3'd2: if (!doe) begin m_oe = 1'b1; m_d = od; end
                    3'd3: if (!doe) begin m_oe = 1'b1; m_d = oc; end
                    default: m_oe = 1'b1;
                endcase
            end
            m_wv = 1'b0;
            if (wn && pend) begin
                m_wv = 1'b1; m_wd = lat; m_wa = oa; pend = 1'b0;
            end
            if (!wn && s == 3'd2 && !doe) begin
                lat = din; pend = 1'b1;
            end
            if (t >= 252 && (t - 28) % 56 == 0) begin
                if (q.size() != 0) {m_addr, m_data, m_ctrl} = q.pop_front();
                else begin
                    m_data = 8'hFF; m_ctrl = 8'hFF;
                    if (m_und != 16'hFFFF) m_und++;
                end
            end
            if (v && m_ready) q.push_back(ent);
            m_ready = q.size() != 4;
        end
        #1;
        chk("a2_7M", 32'(a2_7M), 32'((t / 4) % 2));
        chk("a2_phi1", 32'(a2_phi1), 32'((t / 28) % 2));
        chk("a2_reset_n", 32'(a2_reset_n), 32'(t >= 197));
        chk("cyc_ready", 32'(cyc_ready), 32'(m_ready));
        chk("underrun", 32'(underrun), 32'(m_und));
        chk("d_out", 32'(d_out), 32'(m_d));
        chk("d_oe", 32'(d_oe), 32'(m_oe));
        chk("wr_valid", 32'(wr_valid), 32'(m_wv));
        chk("wr_data", 32'(wr_data), 32'(m_wd));
        chk("wr_addr", 32'(wr_addr), 32'(m_wa));
    endtask

    task automatic rand_in(input int push_pct);
        cyc_valid = $urandom_range(0, 99) < push_pct;
        cyc_addr = 16'($urandom); cyc_data = 8'($urandom); cyc_ctrl = 8'($urandom);
        sel = 3'($urandom_range(0, 7));
        a_oe_n = $urandom_range(0, 3) == 0;
        d_oe_n = $urandom_range(0, 3) == 0;
        rd_n = $urandom_range(0, 1) == 0;
        wr_n = $urandom_range(0, 3) != 0;
        d_in = 8'($urandom);
    endtask

    task automatic idle_in();
        cyc_valid = 1'b0; rd_n = 1'b1; wr_n = 1'b1; a_oe_n = 1'b1; d_oe_n = 1'b1; sel = '0;
    endtask

    task automatic push_in(input logic [15:0] a, input logic [7:0] d, input logic [7:0] c);
        cyc_valid = 1'b1; cyc_addr = a; cyc_data = d; cyc_ctrl = c;
    endtask

    initial begin
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_ready", 32'(cyc_ready), 32'd0);
        chk("rst_d_out", 32'(d_out), 32'hFF);
        chk("rst_reset_n", 32'(a2_reset_n), 32'd0);

        // five back-to-back pushes into a four-entry FIFO before any pop
        for (int i = 0; i < 5; i++) tick();
        push_in(16'hC0A5, 8'h3C, 8'h7F); tick();
        for (int i = 0; i < 3; i++) begin push_in(16'(16'h1000 + i), 8'(i), 8'(i)); tick(); end
        chk("fifo_full", 32'(cyc_ready), 32'd0);
        push_in(16'hDEAD, 8'hBE, 8'hEF); tick();
        chk("fifo_still_full", 32'(cyc_ready), 32'd0);
        idle_in();
        while (t < 240) begin rand_in(0); tick(); end
        idle_in();
        while (t < 252) tick();
        chk("ready_after_pop", 32'(cyc_ready), 32'd1);

        rd_n = 1'b0; a_oe_n = 1'b0; d_oe_n = 1'b0;
        sel = 3'd0; tick(); chk("replay_lo", 32'(d_out), 32'hA5); chk("replay_lo_oe", 32'(d_oe), 32'd1);
        sel = 3'd1; tick(); chk("replay_hi", 32'(d_out), 32'hC0);
        sel = 3'd2; tick(); chk("replay_data", 32'(d_out), 32'h3C);
        sel = 3'd3; tick(); chk("replay_ctrl", 32'(d_out), 32'h7F);
        sel = 3'd0; a_oe_n = 1'b1; tick();
        chk("gate_oe", 32'(d_oe), 32'd0); chk("gate_d", 32'(d_out), 32'hFF);
        sel = 3'd6; tick();
        chk("sel6_oe", 32'(d_oe), 32'd1); chk("sel6_d", 32'(d_out), 32'hFF);

        rd_n = 1'b1; sel = 3'd2; d_oe_n = 1'b0; wr_n = 1'b0;
        d_in = 8'h11; tick(); d_in = 8'h22; tick(); d_in = 8'h5A; tick();
        wr_n = 1'b1; tick();
        chk("wcap_valid", 32'(wr_valid), 32'd1);
        chk("wcap_data", 32'(wr_data), 32'h5A);
        chk("wcap_addr", 32'(wr_addr), 32'hC0A5);
        tick();
        chk("wcap_pulse_end", 32'(wr_valid), 32'd0);
        sel = 3'd1; wr_n = 1'b0;
        tick(); tick(); tick();
        wr_n = 1'b1; tick();
        chk("wcap_nosel", 32'(wr_valid), 32'd0);
        tick();
        chk("wcap_nosel2", 32'(wr_valid), 32'd0);

        while (t < 1100) begin rand_in(3); tick(); end
        idle_in();
        while (t < 1500) begin rand_in(0); tick(); end
        chk("underrun_nonzero", 32'(underrun != 16'd0), 32'd1);

        idle_in();
        for (int i = 0; i < 3; i++) begin push_in(16'(16'h2000 + i), 8'hAA, 8'h55); tick(); end
        cyc_valid = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_rst_ready", 32'(cyc_ready), 32'd0);
        chk("mid_rst_reset_n", 32'(a2_reset_n), 32'd0);
        chk("mid_rst_underrun", 32'(underrun), 32'd0);
        chk("mid_rst_phi1", 32'(a2_phi1), 32'd0);
        chk("mid_rst_7m", 32'(a2_7M), 32'd0);
        while (t < 400) begin rand_in(5); tick(); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
